// File: rtl/pipe_stage_pkg.sv
// Shared types and constants for the pipeline-stage register.
// Used by pipe_stage_slot and pipe_stage_reg.
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  localparam int OCC_W = 2;

  localparam logic NOP_BIT = 1'b0;

endpackage

// File: rtl/pipe_stage_slot.sv
// One payload register with load enable and synchronous clear to NOP.
// Clear has priority over load.
module pipe_stage_slot
  import pipe_stage_pkg::*;
#(
  parameter int WIDTH = 96,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{NOP_BIT}}
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (clr)
      data_d = NOP_VALUE;
    else if (load)
      data_d = d;
  end

  always_ff @(posedge clock) begin
    data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline-stage register with flush-to-NOP.
// Define PIPE_STAGE_SKID_EN for the skid entry (registered in_ready).
module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int WIDTH = 96,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{NOP_BIT}}
) (
  input  logic             clock,
  input  logic             clr_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  stage_state_e     state_q;
  stage_state_e     state_d;
  logic             in_fire;
  logic             out_fire;
  logic             slot_clr;
  logic             main_ld;
  logic             main_from_skid;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;

  assign out_valid = clr_n && (state_q != ST_EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign slot_clr  = !clr_n || flush;
  assign out_data  = main_q;

`ifdef PIPE_STAGE_SKID_EN
  logic             skid_ld;
  logic [WIDTH-1:0] skid_q;

  assign in_ready  = clr_n && (state_q != ST_TWO);
  assign occupancy = clr_n ? state_q : '0;
  assign main_d    = main_from_skid ? skid_q : in_data;

  pipe_stage_slot #(
    .WIDTH     (WIDTH),
    .NOP_VALUE (NOP_VALUE)
  ) u_skid (
    .clock (clock),
    .clr   (slot_clr),
    .load  (skid_ld),
    .d     (in_data),
    .q     (skid_q)
  );
`else
  assign in_ready  = clr_n && (!out_valid || out_ready);
  assign occupancy = {1'b0, clr_n && (state_q == ST_ONE)};
  assign main_d    = in_data;
`endif

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    skid_ld        = 1'b0;
`endif
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          main_ld = 1'b1;
        end
      end
      ST_ONE: begin
        if (out_fire) begin
          main_ld = in_fire;
          state_d = in_fire ? ST_ONE : ST_EMPTY;
        end
`ifdef PIPE_STAGE_SKID_EN
        else if (in_fire) begin
          state_d = ST_TWO;
          skid_ld = 1'b1;
        end
`endif
      end
`ifdef PIPE_STAGE_SKID_EN
      ST_TWO: begin
        if (out_fire) begin
          state_d        = ST_ONE;
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
`endif
      default: state_d = ST_EMPTY;
    endcase
    // flush wins over any same-cycle transfer
    if (flush)
      state_d = ST_EMPTY;
  end

  always_ff @(posedge clock) begin
    if (!clr_n)
      state_q <= ST_EMPTY;
    else
      state_q <= state_d;
  end

  pipe_stage_slot #(
    .WIDTH     (WIDTH),
    .NOP_VALUE (NOP_VALUE)
  ) u_main (
    .clock (clock),
    .clr   (slot_clr),
    .load  (main_ld),
    .d     (main_d),
    .q     (main_q)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg.
// Reference is a payload queue with a capacity limit.
module tb_pipe_stage_reg;

  localparam int W = 96;
  localparam logic [W-1:0] NOP = '0;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic         clock = 1'b0;
  logic         clr_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  logic [W-1:0] mq[$];
  bit           nop_exp;
  int           n_checks;
  int           n_fail;

  always #5 clock = ~clock;

  pipe_stage_reg #(
    .WIDTH     (W),
    .NOP_VALUE (NOP)
  ) dut (
    .clock     (clock),
    .clr_n     (clr_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  task automatic check_eq(input string tag,
                          input logic [W-1:0] obs,
                          input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rn, input bit fl,
                      input bit iv, input logic [W-1:0] d,
                      input bit ordy);
    bit exp_rdy;
    bit exp_vld;
    int occ;
    @(negedge clock);
    clr_n     = rn;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    exp_vld = rn && (mq.size() > 0);
    if (CAP == 2)
      exp_rdy = rn && (mq.size() < 2);
    else
      exp_rdy = rn && (mq.size() == 0 || ordy);
    occ = rn ? mq.size() : 0;
    check_eq("in_ready", W'(in_ready), W'(exp_rdy));
    check_eq("out_valid", W'(out_valid), W'(exp_vld));
    check_eq("occupancy", W'(occupancy), W'(occ));
    if (exp_vld)
      check_eq("out_data", out_data, mq[0]);
    else if (nop_exp)
      check_eq("out_data_nop", out_data, NOP);
    if (!rn || fl) begin
      mq.delete();
      nop_exp = 1'b1;
    end else begin
      if (exp_vld && ordy)
        void'(mq.pop_front());
      if (iv && exp_rdy) begin
        mq.push_back(d);
        nop_exp = 1'b0;
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    nop_exp   = 1'b1;
    clr_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = W'(32'h99);
    out_ready = 1'b0;
    @(posedge clock);

    repeat (3) step(0, 0, 1, W'(32'h99), 0);
    step(1, 0, 0, '0, 0);

    step(1, 0, 1, W'(32'h1), 1);
    step(1, 0, 1, W'(32'h2), 1);
    step(1, 0, 1, W'(32'h3), 1);
    repeat (3) step(1, 0, 0, '0, 1);

    step(1, 0, 1, W'(32'hA), 0);
    step(1, 0, 1, W'(32'hB), 0);
    step(1, 0, 1, W'(32'hD), 0);
    step(1, 0, 0, '0, 0);
    repeat (3) step(1, 0, 0, '0, 1);

    step(1, 0, 1, W'(32'h11), 0);
    step(1, 0, 1, W'(32'h12), 0);
    step(1, 0, 1, W'(32'h12), 1);
    step(1, 0, 0, '0, 1);
    step(1, 0, 0, '0, 1);

    step(1, 0, 1, W'(32'hA), 0);
    step(1, 0, 1, W'(32'hB), 0);
    step(1, 1, 1, W'(32'hC), 0);
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 1);

    step(1, 0, 1, W'(32'h7), 0);
    step(0, 0, 1, W'(32'h8), 1);
    step(1, 0, 1, W'(32'h5), 1);
    step(1, 0, 0, '0, 1);
    step(1, 0, 0, '0, 1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 59) != 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 6,
           {$urandom(), $urandom(), $urandom()},
           $urandom_range(0, 9) < 6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
